// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Brief    : APU frame sequencer. A 16-bit cycle counter generates the
//            quarter-frame and half-frame clock pulses in 4-step or 5-step
//            mode, and an optional sticky frame interrupt.
// Options  : FRAME_SEQUENCER_IRQ_EN - compiles in the frame_irq set/clear
//            logic and the IRQ inhibit bit; without it frame_irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_read,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode
);

  localparam logic [15:0] c_step1   = 16'(STEP1);
  localparam logic [15:0] c_step2   = 16'(STEP2);
  localparam logic [15:0] c_step3   = 16'(STEP3);
  localparam logic [15:0] c_step4   = 16'(STEP4);
  localparam logic [15:0] c_step4m1 = 16'(STEP4 - 1);
  localparam logic [15:0] c_step5   = 16'(STEP5);

  logic [15:0] r_cnt;
  logic        r_mode;
  logic        r_qf;
  logic        r_hf;

  logic        w_wrap;
  logic [15:0] w_cnt_nxt;
  logic        w_mode_nxt;
  logic [15:0] w_final_nxt;
  logic        w_kick;
  logic        w_qf_nxt;
  logic        w_hf_nxt;

  // Next counter/mode; outputs are decoded from the next count so that the
  // registered pulses are high exactly while the counter holds the step value.
  always_comb begin
    w_wrap      = r_mode ? (r_cnt >= c_step5) : (r_cnt >= c_step4);
    w_kick      = wr_en & wr_data[7];
    w_mode_nxt  = wr_en ? wr_data[7] : r_mode;
    w_cnt_nxt   = (wr_en || w_wrap) ? 16'd0 : r_cnt + 16'd1;
    w_final_nxt = w_mode_nxt ? c_step5 : c_step4;
    w_qf_nxt    = w_kick || (w_cnt_nxt == c_step1) || (w_cnt_nxt == c_step2) ||
                  (w_cnt_nxt == c_step3) || (w_cnt_nxt == w_final_nxt);
    w_hf_nxt    = w_kick || (w_cnt_nxt == c_step2) || (w_cnt_nxt == w_final_nxt);
  end

  // Counter, mode and frame-clock pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= 16'd0;
      r_mode <= 1'b0;
      r_qf   <= 1'b0;
      r_hf   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mode <= w_mode_nxt;
      r_qf   <= w_qf_nxt;
      r_hf   <= w_hf_nxt;
    end
  end

  assign quarter_frame = r_qf;
  assign half_frame    = r_hf;
  assign mode          = r_mode;

`ifdef FRAME_SEQUENCER_IRQ_EN
  logic r_inhibit;
  logic r_irq;
  logic w_inhibit_nxt;
  logic w_irq_set;
  logic w_irq_wr_clr;
  logic w_unused;

  // IRQ is raised on the last two counts of a 4-step frame unless inhibited.
  always_comb begin
    w_inhibit_nxt = wr_en ? wr_data[6] : r_inhibit;
    w_irq_wr_clr  = wr_en & wr_data[6];
    w_irq_set     = !w_mode_nxt && !w_inhibit_nxt &&
                    ((w_cnt_nxt == c_step4m1) || (w_cnt_nxt == c_step4));
  end

  // Sticky IRQ: inhibit-write clear beats set, set beats status-read clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_inhibit <= w_inhibit_nxt;
      if (w_irq_wr_clr) begin
        r_irq <= 1'b0;
      end else if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (status_read) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign frame_irq = r_irq;
  // Low register bits carry no meaning for the frame counter.
  assign w_unused  = &{1'b0, wr_data[5:0]};
`else
  logic w_unused;

  assign frame_irq = 1'b0;
  // Without the IRQ logic, status reads and the inhibit bit have no effect.
  assign w_unused  = &{1'b0, status_read, wr_data[6:0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Self-checking bench for frame_sequencer with scaled step counts.
//            The reference model tracks the frame start and derives the
//            position in the frame arithmetically from elapsed clock edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

  localparam int S1 = 74;
  localparam int S2 = 149;
  localparam int S3 = 223;
  localparam int S4 = 298;
  localparam int S5 = 372;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       status_read = 1'b0;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic       mode;

  frame_sequencer #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .status_read  (status_read),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .frame_irq    (frame_irq),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges seen, edge index of the current frame start.
  int edges  = 0;
  int base   = 0;
  bit m_mode = 1'b0;
  bit m_inh  = 1'b0;
  bit m_irq  = 1'b0;
  bit m_kick = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len();
    return m_mode ? S5 + 1 : S4 + 1;
  endfunction

  function automatic int pos();
    return (edges - base) % frame_len();
  endfunction

  function automatic bit exp_qf();
    int p = pos();
    return m_kick || p == S1 || p == S2 || p == S3 || p == (m_mode ? S5 : S4);
  endfunction

  function automatic bit exp_hf();
    int p = pos();
    return m_kick || p == S2 || p == (m_mode ? S5 : S4);
  endfunction

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit sr);
    int p;
    edges++;
    m_kick = 1'b0;
    if (wr) begin
      base   = edges;
      m_mode = d[7];
      m_inh  = d[6];
      m_kick = d[7];
    end
    p = pos();
    if (wr && d[6]) m_irq = 1'b0;
    else if (!m_mode && !m_inh && (p == S4 - 1 || p == S4)) m_irq = 1'b1;
    else if (sr) m_irq = 1'b0;
  endtask

  task automatic compare_all();
    check_val("quarter_frame", quarter_frame, exp_qf());
    check_val("half_frame", half_frame, exp_hf());
`ifdef FRAME_SEQUENCER_IRQ_EN
    check_val("frame_irq", frame_irq, m_irq);
`else
    check_val("frame_irq", frame_irq, 0);
`endif
    check_val("mode", mode, m_mode);
  endtask

  // One clock with the given inputs; called #1 after a rising edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit sr);
    wr_en = wr;
    wr_data = d;
    status_read = sr;
    @(posedge clk);
    model_edge(wr, d, sr);
    #1;
    wr_en = 1'b0;
    status_read = 1'b0;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_to_pos(input int target);
    for (int i = 0; i < 2 * (S5 + 1) && pos() != target; i++) step(1'b0, 8'h00, 1'b0);
    if (pos() != target) check_val("run_to_pos_timeout", pos(), target);
  endtask

  // Steps until quarter_frame is seen; n is the number of edges taken.
  task automatic wait_qf(output int n);
    n = 0;
    do begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end while (!quarter_frame && n < 2 * (S5 + 1));
    if (!quarter_frame) check_val("wait_qf_timeout", quarter_frame, 1);
  endtask

  // Asynchronous mid-cycle reset held for n edges, released between edges.
  task automatic do_reset(input int n);
    #2;
    reset_n = 1'b0;
    #1;
    base = edges; m_mode = 0; m_inh = 0; m_irq = 0; m_kick = 0;
    check_val("rst_quarter_frame", quarter_frame, 0);
    check_val("rst_half_frame", half_frame, 0);
    check_val("rst_frame_irq", frame_irq, 0);
    check_val("rst_mode", mode, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edges++;
      base = edges;
      #1;
      compare_all();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    // Power-on reset.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Idle 4-step frames; first quarter frame S1 edges after release.
    wait_qf(n);
    check_val("first_qf_after_reset", n, S1);
    run(2 * (S4 + 1));

    // 5-step mode: immediate pulse pair, no events at S4.
    step(1'b1, 8'h80, 1'b0);
    run(2 * (S5 + 1) + 3);

    // 4-step with IRQ: rises at S4-1, sticky across wrap, cleared by read.
    step(1'b1, 8'h00, 1'b0);
    run_to_pos(S4 - 1);
    run(5);
    step(1'b0, 8'h00, 1'b1);
    run_to_pos(S4 - 2);
    step(1'b0, 8'h00, 1'b1);
    run(3);
    step(1'b0, 8'h00, 1'b1);

    // Inhibit write while IRQ is high, then re-enable.
    run_to_pos(S4 - 1);
    step(1'b1, 8'h40, 1'b0);
    run(2 * (S4 + 1));
    step(1'b1, 8'h00, 1'b0);
    run_to_pos(S4 - 1);
    run(3);

    // Back-to-back writes: the last one wins.
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    run(S4 + 5);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    run(S5 + 5);

    // Reset mid-frame abandons the pending S2 event.
    step(1'b1, 8'h00, 1'b0);
    run_to_pos(140);
    do_reset(3);
    wait_qf(n);
    check_val("qf_after_midframe_reset", n, S1);
    check_val("mode_after_reset", mode, 0);

    // Write exactly on the S1 count: that pulse stays, next is S1 edges on.
    run_to_pos(S1 - 1);
    step(1'b0, 8'h00, 1'b0);
    check_val("qf_on_write_cycle", quarter_frame, 1);
    step(1'b1, 8'h00, 1'b0);
    wait_qf(n);
    check_val("qf_after_write_at_s1", n, S1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r == 999) begin
        do_reset($urandom_range(1, 3));
      end else if (r < 3) begin
        step(1'b1, 8'($urandom), 1'b0);
      end else if (r < 30) begin
        step(1'b0, 8'h00, 1'b1);
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
